// File: rtl/out_fm_acc_fifo_to_ram.sv
// Output feature-map tile writer: drains the conv-core FIFO into the output RAM at global
// (n,row,col) addresses with clipping, optional read-modify-write accumulate. Optional ReLU: OUT_FM_RELU_EN.
module out_fm_acc_fifo_to_ram #(
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned N  = 32,
  parameter int unsigned R  = 64,
  parameter int unsigned C  = 32,
  parameter int unsigned K  = 3,
  parameter int unsigned S  = 1,
  parameter int unsigned Tn = 8,
  parameter int unsigned Tr = 16,
  parameter int unsigned Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc_mode,
  input  logic          relu_en,
  input  logic          abort,
  input  logic [AW-1:0] tile_base_n,
  input  logic [AW-1:0] tile_base_row,
  input  logic [AW-1:0] tile_base_col,
  output logic          busy,
  output logic          done,
  output logic          fifo_pop,
  input  logic          fifo_empty,
  input  logic [DW-1:0] data_from_fifo,
  output logic          ram_rd_ena,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          ram_wena,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] data_to_ram
);

  localparam int unsigned row_step = ((Tr + S - K) / S) * S;
  localparam int unsigned col_step = ((Tc + S - K) / S) * S;
  localparam int unsigned r_step   = ((R + S - K) / S) * S;
  localparam int unsigned c_step   = ((C + S - K) / S) * S;
  localparam int unsigned EW       = ((AW > CW) ? AW : CW) + 1;
  localparam logic [AW-1:0] rc_a   = AW'(R * C);
  localparam logic [AW-1:0] c_a    = AW'(C);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tn_q, tr_q, tc_q;
  logic [AW-1:0] base_n_q, base_row_q, base_col_q;
  logic          acc_q;

  logic          s1_valid, s1_legal, s1_last;
  logic [AW-1:0] s1_addr;
  logic          s2_valid, s2_legal, s2_last;
  logic [AW-1:0] s2_addr;
  logic [DW-1:0] s2_data;

  logic          pop_c, last_elem_c, legal_c, done_slot_c;
  logic [EW-1:0] n_sum_c, r_sum_c, c_sum_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wr_raw_c, wr_val_c;

  // Global coordinates of the element at the counter position.
  assign n_sum_c = EW'(base_n_q)   + EW'(tn_q);
  assign r_sum_c = EW'(base_row_q) + EW'(tr_q);
  assign c_sum_c = EW'(base_col_q) + EW'(tc_q);

  assign legal_c = (n_sum_c < EW'(N)) && (r_sum_c < EW'(r_step)) && (c_sum_c < EW'(c_step)) &&
                   (EW'(tc_q) < EW'(col_step)) && (EW'(tr_q) < EW'(row_step));

  assign addr_c = AW'(n_sum_c) * rc_a + AW'(r_sum_c) * c_a + AW'(c_sum_c);

  assign last_elem_c = (tc_q == CW'(Tc - 1)) && (tr_q == CW'(Tr - 1)) && (tn_q == CW'(Tn - 1));

  // Write stage: FIFO data directly in overwrite mode, registered data + RAM data in accumulate mode.
  assign wr_raw_c = acc_q ? (s2_data + ram_rd_data) : data_from_fifo;

`ifdef OUT_FM_RELU_EN
  logic relu_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      relu_q <= 1'b0;
    end else if (!abort && state_q == IDLE && start) begin
      relu_q <= relu_en;
    end
  end

  assign wr_val_c = (relu_q && wr_raw_c[DW-1]) ? '0 : wr_raw_c;
`else
  logic unused_relu;
  assign unused_relu = relu_en;
  assign wr_val_c    = wr_raw_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop_c       = 1'b0;
    done_slot_c = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fifo_pop    = 1'b0;
    ram_rd_ena  = 1'b0;
    ram_rd_addr = s1_addr;
    ram_wena    = 1'b0;
    ram_wr_addr = s1_addr;
    data_to_ram = '0;

    pop_c       = (state_q == RUN) && !fifo_empty;
    done_slot_c = acc_q ? (s2_valid && s2_last) : (s1_valid && s1_last);

    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pop_c && last_elem_c) state_d = DRAIN;
      DRAIN:   if (done_slot_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;

    busy        = (state_q != IDLE);
    fifo_pop    = pop_c;
    done        = done_slot_c && !abort;
    ram_rd_ena  = s1_valid && s1_legal && acc_q;
    ram_wena    = acc_q ? (s2_valid && s2_legal) : (s1_valid && s1_legal);
    ram_wr_addr = acc_q ? s2_addr : s1_addr;
    data_to_ram = ram_wena ? wr_val_c : '0;
  end

  // Tile counters, latched tile context and the two pipeline stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tn_q       <= '0;
      tr_q       <= '0;
      tc_q       <= '0;
      base_n_q   <= '0;
      base_row_q <= '0;
      base_col_q <= '0;
      acc_q      <= 1'b0;
      s1_valid   <= 1'b0;
      s1_legal   <= 1'b0;
      s1_last    <= 1'b0;
      s1_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_legal   <= 1'b0;
      s2_last    <= 1'b0;
      s2_addr    <= '0;
      s2_data    <= '0;
    end else if (abort) begin
      tn_q     <= '0;
      tr_q     <= '0;
      tc_q     <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        tn_q       <= '0;
        tr_q       <= '0;
        tc_q       <= '0;
        base_n_q   <= tile_base_n;
        base_row_q <= tile_base_row;
        base_col_q <= tile_base_col;
        acc_q      <= acc_mode;
      end else if (pop_c) begin
        if (tc_q == CW'(Tc - 1)) begin
          tc_q <= '0;
          if (tr_q == CW'(Tr - 1)) begin
            tr_q <= '0;
            tn_q <= tn_q + CW'(1);
          end else begin
            tr_q <= tr_q + CW'(1);
          end
        end else begin
          tc_q <= tc_q + CW'(1);
        end
      end

      s1_valid <= pop_c;
      s1_legal <= legal_c;
      s1_last  <= last_elem_c;
      s1_addr  <= addr_c;

      // Stage 2 only carries work in accumulate mode; FIFO data is valid during stage 1.
      s2_valid <= s1_valid && acc_q;
      s2_legal <= s1_legal;
      s2_last  <= s1_last;
      s2_addr  <= s1_addr;
      s2_data  <= data_from_fifo;
    end
  end

endmodule

// File: doc/out_fm_acc_fifo_to_ram.md
# out_fm_acc_fifo_to_ram

Drains one output-feature-map tile from the convolution core's output FIFO into the off-tile output RAM. Each element lands at its global (n, row, col) address, and elements outside the valid output region are clipped. It is the next generation of the output-tile writer: it adds a read-modify-write accumulate mode for partial sums across input-channel tiles and latches the tile base at start. Its write pipeline is aligned to the FIFO's one-cycle pop-to-data latency. It sits between the conv core output FIFO and the output feature-map RAM, under control of the tile scheduler.

## Interface
Parameters:
- CW, 32, counter width
- AW, 16, RAM address width
- DW, 32, data width (two's complement)
- N, 32, output channels
- R, 64, input rows
- C, 32, input cols
- K, 3, kernel size
- S, 1, stride
- Tn, 8, tile channels
- Tr, 16, tile rows
- Tc, 8, tile cols

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begin tile; ignored while busy
- acc_mode  in  1  sampled at start; 1 = accumulate, 0 = overwrite
- relu_en  in  1  sampled at start; final-pass ReLU (see Configuration)
- abort  in  1  synchronous tile clean; clears counters and pipeline, no done
- tile_base_n, tile_base_row, tile_base_col  in  AW each  tile origin, sampled at start
- busy  out  1  high from cycle after start until cycle after done
- done  out  1  one-cycle pulse, tile complete
- fifo_pop  out  1  FIFO pop request
- fifo_empty  in  1  FIFO empty flag
- data_from_fifo  in  DW  FIFO data, valid one cycle after pop
- ram_rd_ena  out  1  RAM read strobe (accumulate mode only)
- ram_rd_addr  out  AW  RAM read address
- ram_rd_data  in  DW  RAM read data, valid one cycle after ram_rd_ena
- ram_wena  out  1  RAM write strobe
- ram_wr_addr  out  AW  RAM write address
- data_to_ram  out  DW  RAM write data

## Operation
- Localparams:
  - row_step = ((Tr+S-K)/S)*S
  - col_step = ((Tc+S-K)/S)*S
  - R_step = ((R+S-K)/S)*S
  - C_step = ((C+S-K)/S)*S
- States:
  - IDLE: start goes to RUN. Latch bases and modes; clear counters.
  - RUN: fifo_pop = !fifo_empty. Each pop advances the nested counters tc (0..Tc-1, innermost), tr, tn. After the Tn*Tr*Tc-th pop, go to DRAIN.
  - DRAIN: no pops. Wait until the pipeline is empty; done fires on the last write slot, then go to IDLE.
- Per pop, capture (tn, tr, tc) into stage 1 with a valid bit and a legal bit.
  - legal = (n+tn<N) && (row+tr<R_step) && (col+tc<C_step) && (tc<col_step) && (tr<row_step)
  - addr = (n+tn)*R*C + (row+tr)*C + col + tc, computed in AW bits, truncated modulo 2^AW.
- Overwrite mode:
  - Stage 1 (pop+1): ram_wena = valid && legal; ram_wr_addr = addr; data_to_ram = data_from_fifo.
- Accumulate mode:
  - Stage 1 (pop+1): ram_rd_ena = valid && legal at addr; FIFO data registered.
  - Stage 2 (pop+2): write of registered FIFO data + ram_rd_data, wrapping DW-bit add, to the same addr.
  - No RAW hazard: addresses within one tile are distinct.
- Illegal elements are always popped, never read or written.
- abort in any state: go to IDLE; counters and valid bits clear; no RAM strobes next cycle; no done. abort has priority over start in the same cycle.
- Reset values: all outputs 0, state IDLE.

## Timing
- Pipeline depth D = 1 in overwrite mode, 2 in accumulate mode.
- First fifo_pop can assert the cycle after start.
- done asserts at cycle (last pop) + D, together with the final write (or the final write slot if that element is illegal).
- busy falls the cycle after done. A start on the done cycle is ignored.
- fifo_empty stalls pops only; in-flight stages still retire.
- With no bubbles, a tile takes Tn*Tr*Tc + D cycles from first pop to done.

## Configuration
- OUT_FM_RELU_EN defined: when relu_en was sampled as 1, any negative value is replaced by 0 at the write stage (the sum in accumulate mode). The ReLU mux sits in the final write stage only.
- OUT_FM_RELU_EN undefined: relu_en is ignored; data written unmodified.

## Test plan
Parameters for all scenarios: N=4, R=C=6, K=3, S=1, Tn=2, Tr=Tc=4. This gives row_step = col_step = 2 and R_step = C_step = 4.
- Overwrite, bases 0, FIFO holds 1..32, never empty -> 8 writes: addresses 0,1,6,7,36,37,42,43 with data 1,2,5,6,17,18,21,22; done 33 cycles after first pop.
- Accumulate, same stimulus, RAM preloaded with 100 -> writes 101,102,105,106,117,118,121,122 at the same addresses; reads precede each write by 1 cycle; done at last pop + 2.
- tile_base_n=3, row=col=2 -> only tn=0 legal; 4 writes at addresses 122,123,128,129; all 32 elements still popped.
- fifo_empty toggled every other cycle in overwrite mode -> identical write set and order; no pop while empty; done 1 cycle after the 32nd pop.
- abort on the 10th pop, then start again -> no done for the first tile; second tile completes normally. rst low mid-tile -> all outputs 0 immediately.
- OUT_FM_RELU_EN defined, relu_en=1, overwrite value -5 at legal element -> 0 written; macro undefined -> -5 written.
